// File: rtl/spsram_128x50_ctrl_if.sv
// rtl/spsram_128x50_ctrl_if.sv - read/write request channels of the single-port SRAM access controller
//
// master : request side (drives rd_req/rd_addr, wr_req/wr_addr/wr_lane_en/wr_data)
// slave  : controller side (drives rd_ack/rd_vld/rd_data, wr_ack)
interface spsram_128x50_ctrl_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 50,
  parameter int WE_WIDTH   = 5
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ack;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WE_WIDTH-1:0]   wr_lane_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_lane_en, wr_data,
    input  rd_ack, rd_vld, rd_data, wr_ack
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_lane_en, wr_data,
    output rd_ack, rd_vld, rd_data, wr_ack
  );
endinterface

// File: rtl/spsram_128x50_ctrl.sv
// rtl/spsram_128x50_ctrl.sv - arbitrating access controller with lane-write RMW for the 128x50 single-port SRAM
//
// Ports:
//   cpuclk    : sole clock, also clocks the SRAM
//   cpurst_b  : synchronous active-low reset
//   bus       : read/write request channels (slave modport)
//   busy      : RMW in progress or init sweep active
//   init_done : SRAM usable
//   ram_cen   : SRAM chip enable, active low
//   ram_wen   : SRAM write enable, active low, all bits equal
//   ram_a     : SRAM address
//   ram_d     : SRAM write data
//   ram_q     : SRAM read data, valid the cycle after a read access
//
// Optional: define SPSRAM_CTRL_INIT_CLR_EN to zero the whole array after every reset.
module spsram_128x50_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 50,
  parameter int WE_WIDTH   = 5
) (
  input  logic                    cpuclk,
  input  logic                    cpurst_b,
  spsram_128x50_ctrl_if.slave     bus,
  output logic                    busy,
  output logic                    init_done,
  output logic                    ram_cen,
  output logic [WE_WIDTH-1:0]     ram_wen,
  output logic [ADDR_WIDTH-1:0]   ram_a,
  output logic [DATA_WIDTH-1:0]   ram_d,
  input  logic [DATA_WIDTH-1:0]   ram_q
);

  localparam int LANE_W = DATA_WIDTH / WE_WIDTH;

  typedef enum logic [2:0] {
`ifdef SPSRAM_CTRL_INIT_CLR_EN
    ST_INIT    = 3'd4,
`endif
    ST_IDLE    = 3'd0,
    ST_RMW_RD  = 3'd1,
    ST_RMW_MRG = 3'd2,
    ST_RMW_WR  = 3'd3
  } state_t;

  state_t                state, state_d;

  logic                  rd_ack_c;
  logic                  wr_ack_c;
  logic                  ld_rmw;
  logic                  rd_pend;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic [WE_WIDTH-1:0]   lat_mask;
  logic [DATA_WIDTH-1:0] merged;

`ifdef SPSRAM_CTRL_INIT_CLR_EN
  logic [ADDR_WIDTH:0]   init_cnt;
  logic [ADDR_WIDTH:0]   init_cnt_inc;

  assign init_cnt_inc = init_cnt + 1'b1;
  assign init_done    = (state != ST_INIT);
`else
  assign init_done    = 1'b1;
`endif

  assign busy        = cpurst_b && (state != ST_IDLE);
  assign bus.rd_ack  = rd_ack_c;
  assign bus.wr_ack  = wr_ack_c;

  always_ff @(posedge cpuclk) begin
    if (!cpurst_b) begin
`ifdef SPSRAM_CTRL_INIT_CLR_EN
      state <= ST_INIT;
`else
      state <= ST_IDLE;
`endif
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    rd_ack_c = 1'b0;
    wr_ack_c = 1'b0;
    ld_rmw   = 1'b0;
    ram_cen  = 1'b1;
    ram_wen  = '1;
    ram_a    = bus.rd_addr;
    ram_d    = bus.wr_data;

    case (state)
`ifdef SPSRAM_CTRL_INIT_CLR_EN
      ST_INIT: begin
        ram_cen = 1'b0;
        ram_wen = '0;
        ram_a   = init_cnt[ADDR_WIDTH-1:0];
        ram_d   = '0;
        if (init_cnt_inc[ADDR_WIDTH]) state_d = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        if (bus.rd_req) begin
          rd_ack_c = 1'b1;
          ram_cen  = 1'b0;
          ram_a    = bus.rd_addr;
        end else if (bus.wr_req && init_done) begin
          wr_ack_c = 1'b1;
          ram_a    = bus.wr_addr;
          ram_d    = bus.wr_data;
          if (&bus.wr_lane_en) begin
            ram_cen = 1'b0;
            ram_wen = '0;
          end else if (|bus.wr_lane_en) begin
            // Partial write: fetch the old word first, the wrapper only writes whole words.
            ram_cen = 1'b0;
            ld_rmw  = 1'b1;
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_RMW_RD:  state_d = ST_RMW_MRG;
      ST_RMW_MRG: state_d = ST_RMW_WR;
      ST_RMW_WR: begin
        ram_cen = 1'b0;
        ram_wen = '0;
        ram_a   = lat_addr;
        ram_d   = merged;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Nothing reaches the SRAM or the requesters while reset is held.
    if (!cpurst_b) begin
      rd_ack_c = 1'b0;
      wr_ack_c = 1'b0;
      ld_rmw   = 1'b0;
      ram_cen  = 1'b1;
      ram_wen  = '1;
    end
  end

  always_ff @(posedge cpuclk) begin
    if (ld_rmw) begin
      lat_addr <= bus.wr_addr;
      lat_data <= bus.wr_data;
      lat_mask <= bus.wr_lane_en;
    end
    if (state == ST_RMW_RD) begin
      for (int i = 0; i < WE_WIDTH; i++) begin
        merged[i*LANE_W +: LANE_W] <= lat_mask[i] ? lat_data[i*LANE_W +: LANE_W]
                                                  : ram_q[i*LANE_W +: LANE_W];
      end
    end
  end

  // Read pipeline: access at T, ram_q captured at end of T+1, rd_vld during T+2.
  always_ff @(posedge cpuclk) begin
    if (!cpurst_b) begin
      rd_pend     <= 1'b0;
      bus.rd_vld  <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      rd_pend    <= rd_ack_c;
      bus.rd_vld <= rd_pend;
      if (rd_pend) bus.rd_data <= ram_q;
    end
  end

`ifdef SPSRAM_CTRL_INIT_CLR_EN
  always_ff @(posedge cpuclk) begin
    if (!cpurst_b) begin
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt_inc;
    end
  end
`endif

endmodule

// File: tb/tb_spsram_128x50_ctrl.sv
// tb/tb_spsram_128x50_ctrl.sv - scoreboard bench for spsram_128x50_ctrl with a behavioural SRAM
module tb_spsram_128x50_ctrl;

  localparam int AW = 7;
  localparam int DW = 50;
  localparam int WW = 5;

  logic           clk = 1'b0;
  logic           rstn;
  logic           busy, init_done, ram_cen;
  logic [WW-1:0]  ram_wen;
  logic [AW-1:0]  ram_a;
  logic [DW-1:0]  ram_d;
  logic [DW-1:0]  ram_q;

  spsram_128x50_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) bus ();

  spsram_128x50_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) dut (
    .cpuclk(clk), .cpurst_b(rstn), .bus(bus), .busy(busy), .init_done(init_done),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM.
  logic [DW-1:0] sram [128];
  always @(posedge clk) begin
    if (!ram_cen) begin
      if (ram_wen == '0) sram[ram_a] <= ram_d;
      else               ram_q <= sram[ram_a];
    end
  end

  // Reference model and scoreboard.
  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] last_rd;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  int            last_ack_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [WW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < WW; i++) if (m[i]) r[i*10 +: 10] = d[i*10 +: 10];
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: checks every rd_vld against the scoreboard, tracks accepted ops into the model.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rstn) begin
      sb.delete();
      last_rd = '0;
`ifdef SPSRAM_CTRL_INIT_CLR_EN
      for (int i = 0; i < 128; i++) ref_mem[i] = '0;
`endif
    end else begin
      if (bus.rd_vld) begin
        if (sb.size() == 0) begin
          check("rd_vld unexpected", 64'(bus.rd_vld), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rd_data", 64'(bus.rd_data), 64'(e.data));
          check("rd_vld cycle", 64'(cyc), 64'(e.due));
        end
        last_rd = bus.rd_data;
      end else begin
        check("rd_data hold", 64'(bus.rd_data), 64'(last_rd));
      end
      if (bus.rd_ack) sb.push_back('{ref_mem[bus.rd_addr], cyc + 2});
      if (bus.wr_ack)
        ref_mem[bus.wr_addr] = merge(ref_mem[bus.wr_addr], bus.wr_data, bus.wr_lane_en);
    end
  end

  task automatic wait_init();
`ifdef SPSRAM_CTRL_INIT_CLR_EN
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (init_done) break;
      if (bus.rd_ack || bus.wr_ack || !busy) check("sweep acks/busy", {bus.rd_ack, bus.wr_ack, busy}, 3'b001);
    end
    check("init_done latency", 64'(k), 64'd128);
`else
    @(negedge clk);
    check("init_done", 64'(init_done), 64'd1);
    check("busy idle", 64'(busy), 64'd0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int t;
    bus.rd_req = 1'b1; bus.rd_addr = a;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.rd_ack) break;
    end
    if (t == 50) check("rd_ack timeout", 64'd0, 64'd1);
    last_ack_cyc = cyc;
    check("rd pins", {ram_cen, ram_wen, ram_a}, {1'b0, 5'h1f, a});
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WW-1:0] m, input logic [DW-1:0] d,
                          input bit hold_rd, input logic [AW-1:0] ra);
    int t;
    logic [DW-1:0] mrg;
    mrg = merge(ref_mem[a], d, m);
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_lane_en = m; bus.wr_data = d;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.wr_ack) break;
    end
    if (t == 50) check("wr_ack timeout", 64'd0, 64'd1);
    last_ack_cyc = cyc;
    if (m == '0)       check("empty wr cen", 64'(ram_cen), 64'd1);
    else if (&m)       check("full wr pins", {ram_cen, ram_wen, ram_a, ram_d}, {1'b0, 5'h00, a, d});
    else               check("rmw rd pins", {ram_cen, ram_wen, ram_a}, {1'b0, 5'h1f, a});
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    if (m != '0 && !(&m)) begin
      if (hold_rd) begin bus.rd_req = 1'b1; bus.rd_addr = ra; end
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        check("rmw busy", 64'(busy), 64'd1);
        check("rmw acks", {bus.rd_ack, bus.wr_ack}, 2'b00);
        check("rmw cen", 64'(ram_cen), (k == 3) ? 64'd0 : 64'd1);
        if (k == 3) check("rmw wr pins", {ram_wen, ram_a, ram_d}, {5'h00, a, mrg});
        @(posedge clk); #1;
      end
      if (hold_rd) begin
        @(negedge clk);
        check("rd_ack after rmw", 64'(bus.rd_ack), 64'd1);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
      end
    end else if (m == '0) begin
      @(negedge clk);
      check("empty wr busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [DW-1:0] old;
    int w;
    for (int i = 0; i < 128; i++) begin
      sram[i]    = {$urandom, $urandom};
      ref_mem[i] = sram[i];
    end
    rstn = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = '0;
    bus.wr_req = 1'b1; bus.wr_addr = '0; bus.wr_lane_en = '1; bus.wr_data = '0;

    // Reset state with both requests asserted.
    @(posedge clk); #1; @(posedge clk); #1;
    @(negedge clk);
    check("reset pins", {bus.rd_ack, bus.wr_ack, ram_cen, ram_wen}, {1'b0, 1'b0, 1'b1, 5'h1f});
    check("reset regs", {bus.rd_vld, busy, bus.rd_data}, {1'b0, 1'b0, 50'd0});
    @(posedge clk); #1;
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    rstn = 1'b1;
    wait_init();

    // Full write then read with T/T+1 handoff.
    do_write(7'd5, 5'h1f, 50'h3_FFFF_FFFF_FFFF, 1'b0, '0);
    w = last_ack_cyc;
    do_read(7'd5);
    check("rd_ack after wr", 64'(last_ack_cyc), 64'(w + 1));

    // Partial-lane RMW.
    do_write(7'd9, 5'h1f, 50'd0, 1'b0, '0);
    do_write(7'd9, 5'b00010, '1, 1'b0, '0);
    do_read(7'd9);
    @(negedge clk);
    @(negedge clk);
    check("rmw result", 64'(bus.rd_data), 64'(50'h00000000FFC00));
    @(posedge clk); #1;

    // Simultaneous requests: read wins, write follows.
    bus.rd_req = 1'b1; bus.rd_addr = 7'd5;
    bus.wr_req = 1'b1; bus.wr_addr = 7'd7; bus.wr_lane_en = 5'h1f; bus.wr_data = 50'h1_2345_6789_ABCD;
    @(negedge clk);
    check("arb acks", {bus.rd_ack, bus.wr_ack}, 2'b10);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("arb wr_ack", 64'(bus.wr_ack), 64'd1);
    @(posedge clk); #1;
    bus.wr_req = 1'b0;

    // Read held through an RMW, then read-after-RMW.
    do_write(7'd7, 5'b10001, 50'h2_AAAA_5555_0F0F, 1'b1, 7'd7);

    // Back-to-back reads at one per cycle.
    do_read(7'd1); w = last_ack_cyc;
    do_read(7'd2); do_read(7'd3); do_read(7'd4);
    check("b2b reads", 64'(last_ack_cyc), 64'(w + 3));

    // Reset while in RMW_MRG: no write may land.
    repeat (4) @(posedge clk); #1;
    do_write(7'd20, 5'h1f, 50'h0_1111_2222_3333, 1'b0, '0);
    old = ref_mem[20];
    bus.wr_req = 1'b1; bus.wr_addr = 7'd20; bus.wr_lane_en = 5'b01100; bus.wr_data = '1;
    @(negedge clk);
    check("abort wr_ack", 64'(bus.wr_ack), 64'd1);
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    check("abort cen mrg", 64'(ram_cen), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort no write", {ram_cen, ram_wen}, {1'b1, 5'h1f});
    @(posedge clk); #1;
    rstn = 1'b1;
`ifndef SPSRAM_CTRL_INIT_CLR_EN
    ref_mem[20] = old;
`endif
    wait_init();
    do_read(7'd20);

    // Reset right after a read accept drops its rd_vld.
    repeat (3) @(posedge clk); #1;
    bus.rd_req = 1'b1; bus.rd_addr = 7'd20;
    @(negedge clk);
    check("pre-reset rd_ack", 64'(bus.rd_ack), 64'd1);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("rd_vld cleared", 64'(bus.rd_vld), 64'd0);
    @(posedge clk); #1;
    wait_init();
`ifdef SPSRAM_CTRL_INIT_CLR_EN
    do_read(7'd0); do_read(7'd64); do_read(7'd127);
`endif

    // Randomized mix.
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      r = $urandom_range(0, 9);
      a = AW'($urandom_range(0, 15));
      d = {$urandom, $urandom};
      if (r <= 3)      do_read(a);
      else if (r <= 5) do_write(a, 5'h1f, d, 1'b0, '0);
      else if (r == 6) do_write(a, 5'h00, d, 1'b0, '0);
      else             do_write(a, WW'($urandom_range(1, 30)), d, ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (6) @(posedge clk);
    @(negedge clk);
    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
